// File: rtl/dsss_bpsk_mod_if.sv
// Bit-input, carrier-input and modulated-output bundle of the DSSS BPSK modulator.
// The DUT uses the slave modport; the source/sink side uses master.
interface dsss_bpsk_mod_if;
    logic               bit_data;
    logic               bit_valid;
    logic               bit_ready;
    logic               car_valid;
    logic signed [15:0] car_data;
    logic               mod_valid;
    logic signed [15:0] mod_data;
    logic               chip;
    logic               sym_start;
    logic [7:0]         underrun_cnt;

    modport master (
        output bit_data, bit_valid, car_valid, car_data,
        input  bit_ready, mod_valid, mod_data, chip, sym_start, underrun_cnt
    );

    modport slave (
        input  bit_data, bit_valid, car_valid, car_data,
        output bit_ready, mod_valid, mod_data, chip, sym_start, underrun_cnt
    );
endinterface

// File: rtl/dsss_bpsk_mod.sv
// DSSS BPSK modulator: each data bit is spread over a 127-chip m-sequence that sign-flips the DDS carrier.
// Optional macro DSSS_NEG_SAT_EN: negating -32768 saturates to +32767 instead of wrapping.
module dsss_bpsk_mod #(
    parameter int unsigned CHIP_DIV = 4,
    parameter logic [6:0]  POLY     = 7'b1100000,
    parameter logic [6:0]  SEED     = 7'h7F
) (
    input  logic           clk_100,
    input  logic           rstn,
    input  logic           en,
    dsss_bpsk_mod_if.slave bus
);
    localparam int DATA_W = 16;
    localparam int DIV_W  = 10;
    localparam logic [DIV_W-1:0]        DIV_LAST  = DIV_W'(CHIP_DIV - 1);
    localparam logic [6:0]              CHIP_LAST = 7'd126;
    localparam logic signed [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] MAX_VAL  = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, LOAD, SPREAD} state_e;

    state_e                     state_q, state_d;
    logic                       bit_q, bit_d;
    logic [6:0]                 lfsr_q, lfsr_d;
    logic [6:0]                 chip_idx_q, chip_idx_d;
    logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
    logic [7:0]                 underrun_q, underrun_d;
    logic                       mod_valid_q, mod_valid_d;
    logic signed [DATA_W-1:0]   mod_data_q, mod_data_d;
    logic                       chip_q, chip_d;
    logic                       sym_start_q, sym_start_d;

    logic       advance, chip_wrap, sym_end, ready, take, pn_chip;
    logic [6:0] lfsr_step;

    function automatic logic signed [DATA_W-1:0] negate(input logic signed [DATA_W-1:0] x);
`ifdef DSSS_NEG_SAT_EN
        if (x == MIN_VAL) return MAX_VAL;
`endif
        return -x;
    endfunction

    assign advance   = (state_q == SPREAD) && bus.car_valid;
    assign chip_wrap = (div_cnt_q == DIV_LAST);
    assign sym_end   = advance && chip_wrap && (chip_idx_q == CHIP_LAST);
    // A new bit is taken in LOAD or on the last advancing cycle of a symbol, so symbols abut without a gap.
    assign ready     = en && ((state_q == LOAD) || sym_end);
    assign take      = ready && bus.bit_valid;
    assign pn_chip   = lfsr_q[6] ^ bit_q;
    assign lfsr_step = {lfsr_q[5:0], ^(lfsr_q & POLY)};

    always_ff @(posedge clk_100 or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = LOAD;
                LOAD:    if (take) state_d = SPREAD;
                SPREAD:  if (sym_end && !take) state_d = LOAD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_d      = bit_q;
        lfsr_d     = lfsr_q;
        chip_idx_d = chip_idx_q;
        div_cnt_d  = div_cnt_q;
        underrun_d = underrun_q;
        if (!en || state_q == IDLE) begin
            lfsr_d     = SEED;
            chip_idx_d = '0;
            div_cnt_d  = '0;
        end else if (take) begin
            bit_d      = bus.bit_data;
            lfsr_d     = SEED;
            chip_idx_d = '0;
            div_cnt_d  = '0;
        end else if (advance) begin
            if (chip_wrap) begin
                div_cnt_d  = '0;
                chip_idx_d = chip_idx_q + 7'd1;
                lfsr_d     = lfsr_step;
            end else begin
                div_cnt_d  = div_cnt_q + DIV_W'(1);
            end
            if (sym_end && underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
        end
    end

    always_comb begin
        mod_valid_d = advance;
        mod_data_d  = '0;
        if (advance) mod_data_d = pn_chip ? negate(bus.car_data) : bus.car_data;
        chip_d      = advance && pn_chip;
        sym_start_d = advance && (chip_idx_q == '0) && (div_cnt_q == '0);
    end

    always_ff @(posedge clk_100 or negedge rstn) begin
        if (!rstn) begin
            bit_q       <= 1'b0;
            lfsr_q      <= SEED;
            chip_idx_q  <= '0;
            div_cnt_q   <= '0;
            underrun_q  <= '0;
            mod_valid_q <= 1'b0;
            mod_data_q  <= '0;
            chip_q      <= 1'b0;
            sym_start_q <= 1'b0;
        end else begin
            bit_q       <= bit_d;
            lfsr_q      <= lfsr_d;
            chip_idx_q  <= chip_idx_d;
            div_cnt_q   <= div_cnt_d;
            underrun_q  <= underrun_d;
            mod_valid_q <= mod_valid_d;
            mod_data_q  <= mod_data_d;
            chip_q      <= chip_d;
            sym_start_q <= sym_start_d;
        end
    end

    assign bus.bit_ready    = ready;
    assign bus.mod_valid    = mod_valid_q;
    assign bus.mod_data     = mod_data_q;
    assign bus.chip         = chip_q;
    assign bus.sym_start    = sym_start_q;
    assign bus.underrun_cnt = underrun_q;
endmodule

// File: doc/dsss_bpsk_mod.md
# dsss_bpsk_mod

Direct-sequence spread-spectrum BPSK modulator that consumes the 16-bit DDS carrier samples and produces the spread, modulated output. Each accepted data bit is XORed with one full period of a 127-chip m-sequence, and each chip flips the carrier sign. The block runs on the DDS clock domain and drives the waveform output of the generator top level.

## Interface
Parameters:
- CHIP_DIV, 4: carrier samples per chip; legal range 1..1023.
- POLY, 7'b1100000: LFSR tap mask, x^7+x^6+1; must be primitive.
- SEED, 7'h7F: LFSR load value at every symbol start; must be nonzero.

Ports:
- clk_100  in  1  system clock, the DDS clock.
- rstn  in  1  reset; asynchronous, active-low.
- en  in  1  run enable.
- bit_data  in  1  data bit to spread.
- bit_valid  in  1  bit_data valid.
- bit_ready  out  1  block accepts bit_data this cycle.
- car_valid  in  1  carrier sample valid (DDS tvalid).
- car_data  in  16  carrier sample, signed two's complement.
- mod_valid  out  1  output sample valid.
- mod_data  out  16  modulated sample, signed.
- chip  out  1  current spread chip (PN XOR data).
- sym_start  out  1  marks first output sample of a symbol.
- underrun_cnt  out  8  saturating count of symbol underruns.

## Operation
- **FSM states:** IDLE, LOAD, SPREAD.
- **IDLE:**
  - bit_ready=0 and mod_valid=0.
  - Goes to LOAD when en=1.
- **LOAD:**
  - bit_ready=1.
  - On bit_valid&bit_ready: latch bit_data, set lfsr=SEED, chip_idx=0, div_cnt=0, then go to SPREAD.
- **SPREAD:**
  - On each car_valid=1 cycle, div_cnt increments.
  - When div_cnt hits CHIP_DIV-1, it wraps to 0, chip_idx increments, and lfsr shifts.
  - LFSR update: lfsr <= {lfsr[5:0], ^(lfsr & POLY)}. PN chip = lfsr[6].
  - Cycles with car_valid=0 freeze all counters.
- **Chip and modulation:**
  - chip = lfsr[6] XOR latched bit.
  - chip=0 passes car_data; chip=1 outputs the negated car_data.
- **Symbol end:** the final advancing cycle is chip_idx=126, div_cnt=CHIP_DIV-1, car_valid=1.
  - bit_ready=1 in that cycle.
  - If handshaked: next cycle stays in SPREAD with the new bit, lfsr=SEED, counters at 0, with no gap.
  - Otherwise: go to LOAD and underrun_cnt increments, saturating at 255.
- **Underrun counting:** the IDLE->LOAD transition never counts as an underrun.
- **en=0 in any state:** go to IDLE next cycle. The current symbol is aborted and the latched bit is discarded. The next symbol restarts from SEED.
- **Reset:** an asynchronous rstn=0 forces IDLE and clears counters, lfsr=SEED, and underrun_cnt=0. This applies mid-symbol as well.

## Timing
- **Reset value of every output:** bit_ready=0, mod_valid=0, mod_data=0, chip=0, sym_start=0, underrun_cnt=0.
- **Latency:** one register stage.
  - mod_valid(t+1) = car_valid(t) & (state(t)==SPREAD).
  - mod_data(t+1) = ±car_data(t).
  - chip(t+1) = chip applied at t.
- **Idle output:** mod_data=0 whenever mod_valid=0.
- **sym_start:** equals 1 only with the mod_valid sample taken at chip_idx=0, div_cnt=0.
- **Symbol length:** exactly 127*CHIP_DIV car_valid cycles.
- **Handshake:** a transfer happens only on a clock edge where bit_valid=1 and bit_ready=1. bit_data need not be held after that edge.
- **Throughput:** a continuous bit stream with car_valid held high produces an unbroken mod_valid stream.

## Configuration
- Macro: DSSS_NEG_SAT_EN.
  - Defined: negating car_data=-32768 yields +32767 (saturated).
  - Undefined: negation wraps, so -32768 outputs -32768.
  - All other values are identical either way.

## Test plan
- **Bit 0, first samples:** CHIP_DIV=4, SEED=7'h7F, car_data=1000 constant with car_valid=1, one bit 0 -> first 4 mod_data=-1000, chip=1, sym_start=1 on sample 0 only.
- **Full symbol, bit 0:** same setup -> 508 valid samples; 256 are -1000 and 252 are +1000 (sum -4000); then bit_ready=1 and underrun_cnt=1.
- **Back-to-back bits:** bits 1 then 0 supplied back-to-back -> 1016 contiguous valid samples. The first symbol sums to +4000 and the second to -4000. sym_start occurs at samples 0 and 508. underrun_cnt=0.
- **Carrier stalls:** car_valid toggling 1/0 -> counters advance only on valid cycles. The symbol spans 1016 clocks and the chip sequence is unchanged.
- **Negation boundary:** car_data=-32768 with chip=1 -> 32767 with DSSS_NEG_SAT_EN, -32768 without.
- **Abort and reset:** en dropped at sample 100 -> mod_valid=0 within 2 cycles and the next symbol restarts from SEED. rstn pulsed mid-symbol -> all outputs 0 immediately.
